// File: rtl/sc_cmdpulse_pkg.sv
// Shared state encodings, default parameters and width helper for the
// multi-channel command pulse generator.
package sc_cmdpulse_pkg;

  localparam int DEFAULT_CHANNELS      = 4;
  localparam int DEFAULT_REPEAT_DELAY  = 16;
  localparam int DEFAULT_REPEAT_PERIOD = 8;

  localparam logic [2:0] RESET_0 = 3'd0;
  localparam logic [2:0] START_0 = 3'd1;
  localparam logic [2:0] CHECK_0 = 3'd2;
  localparam logic [2:0] PULSE_0 = 3'd3;
  localparam logic [2:0] HOLD_0  = 3'd4;

  // Index width for a channel count, never narrower than one bit
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_prio_enc_low.sv
// Priority encoder for active-low requests: reports the lowest-numbered
// channel whose request bit is 0, plus a valid flag when any bit is low.
module sc_prio_enc_low
  import sc_cmdpulse_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic [CHANNELS-1:0]           reqLow,
  output logic [idxWidth(CHANNELS)-1:0] index,
  output logic                          valid
);

  localparam int IDX_W = idxWidth(CHANNELS);

  // Scan from the top down so the lowest-numbered low bit makes the final assignment
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (!reqLow[i]) begin
        index = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_cmdpulse_multi.sv
// Multi-channel command pulse generator: captures the lowest-numbered
// pressed channel, issues one active-low strobe, then optionally
// auto-repeats while the owner stays held.
module sc_cmdpulse_multi
  import sc_cmdpulse_pkg::*;
#(
  parameter int CHANNELS      = DEFAULT_CHANNELS,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic                          SC_CMDPULSE_MULTI_CLOCK_50,
  input  logic                          SC_CMDPULSE_MULTI_RESET_InLow,
  input  logic [CHANNELS-1:0]           SC_CMDPULSE_MULTI_req_InLow,
  input  logic                          SC_CMDPULSE_MULTI_repeat_InHigh,
  output logic [CHANNELS-1:0]           SC_CMDPULSE_MULTI_pulse_OutLow,
  output logic                          SC_CMDPULSE_MULTI_busy_OutHigh,
  output logic [idxWidth(CHANNELS)-1:0] SC_CMDPULSE_MULTI_index_Out
);

  localparam int IDX_W = idxWidth(CHANNELS);
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]       state;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] repeatCount;
  logic             repeatingFlag;
  logic [IDX_W-1:0] encIndex;
  logic             encValid;
  logic             ownerReleased;
  logic [CNT_W-1:0] countLast;

  sc_prio_enc_low #(
    .CHANNELS(CHANNELS)
  ) prioEnc (
    .reqLow(SC_CMDPULSE_MULTI_req_InLow),
    .index (encIndex),
    .valid (encValid)
  );

  assign ownerReleased = SC_CMDPULSE_MULTI_req_InLow[owner];
  assign countLast     = repeatingFlag ? PERIOD_LAST : DELAY_LAST;

  // Control FSM with owner capture and the auto-repeat counter
  always_ff @(posedge SC_CMDPULSE_MULTI_CLOCK_50 or negedge SC_CMDPULSE_MULTI_RESET_InLow) begin
    if (!SC_CMDPULSE_MULTI_RESET_InLow) begin
      state         <= RESET_0;
      owner         <= '0;
      repeatCount   <= '0;
      repeatingFlag <= 1'b0;
    end else begin
      case (state)
        RESET_0: state <= START_0;
        START_0: state <= CHECK_0;
        CHECK_0: begin
          repeatingFlag <= 1'b0;
          repeatCount   <= '0;
          if (encValid) begin
            owner <= encIndex;
            state <= PULSE_0;
          end
        end
        PULSE_0: begin
          repeatCount <= '0;
          state       <= HOLD_0;
        end
        HOLD_0: begin
          if (ownerReleased) begin
            repeatCount   <= '0;
            repeatingFlag <= 1'b0;
            state         <= CHECK_0;
          end else if (SC_CMDPULSE_MULTI_repeat_InHigh) begin
            if (repeatCount == countLast) begin
              repeatingFlag <= 1'b1;
              state         <= PULSE_0;
            end else begin
              repeatCount <= repeatCount + CNT_ONE;
            end
          end else begin
            repeatCount <= '0;
          end
        end
        default: begin
          repeatCount   <= '0;
          repeatingFlag <= 1'b0;
          state         <= CHECK_0;
        end
      endcase
    end
  end

  // Moore output decode from registered state and owner only
  always_comb begin
    SC_CMDPULSE_MULTI_pulse_OutLow = '1;
    if (state == PULSE_0) begin
      SC_CMDPULSE_MULTI_pulse_OutLow[owner] = 1'b0;
    end
    SC_CMDPULSE_MULTI_busy_OutHigh = (state == PULSE_0) || (state == HOLD_0);
    SC_CMDPULSE_MULTI_index_Out    = owner;
  end

endmodule

// File: tb/tb_sc_cmdpulse_multi.sv
// Self-checking bench for sc_cmdpulse_multi with default parameters.
// Expected strobes are queued when a request is driven and matched
// against observed strobes as they appear.
module tb_sc_cmdpulse_multi;
  import sc_cmdpulse_pkg::*;

  typedef struct {
    int         rel;
    logic [3:0] pulse;
    logic [1:0] idx;
  } strobe_t;

  logic       clk;
  logic       rstN;
  logic [3:0] req;
  logic       rpt;
  logic [3:0] pulse;
  logic       busy;
  logic [1:0] idx;

  int checks = 0;
  int fails  = 0;
  strobe_t expQ[$];

  sc_cmdpulse_multi dut (
    .SC_CMDPULSE_MULTI_CLOCK_50     (clk),
    .SC_CMDPULSE_MULTI_RESET_InLow  (rstN),
    .SC_CMDPULSE_MULTI_req_InLow    (req),
    .SC_CMDPULSE_MULTI_repeat_InHigh(rpt),
    .SC_CMDPULSE_MULTI_pulse_OutLow (pulse),
    .SC_CMDPULSE_MULTI_busy_OutHigh (busy),
    .SC_CMDPULSE_MULTI_index_Out    (idx)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values and the two-cycle walk to CHECK_0
  task automatic test_reset();
    rstN = 1'b0;
    req  = 4'hF;
    rpt  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pulse !== 4'hF) begin fails++; $display("[TB] FAIL reset_pulse got %b want 1111", pulse); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_index got %0d want 0", idx); end
    rstN = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (dut.state !== ((i == 1) ? START_0 : CHECK_0)) begin
        fails++; $display("[TB] FAIL reset_walk cycle %0d state %0d want %0d", i, dut.state, (i == 1) ? START_0 : CHECK_0);
      end
      checks++;
      if (pulse !== 4'hF || busy !== 1'b0) begin
        fails++; $display("[TB] FAIL reset_walk_outputs cycle %0d pulse %b busy %b want 1111/0", i, pulse, busy);
      end
    end
  endtask

  // Single press on channel 2 without auto-repeat
  task automatic test_single();
    strobe_t e;
    rpt = 1'b0;
    req = 4'b1011;
    expQ.push_back('{rel: 1, pulse: 4'b1011, idx: 2'd2});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pulse !== 4'hF) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++; $display("[TB] FAIL single_strobe unexpected pulse %b at cycle %0d", pulse, i);
        end else begin
          e = expQ.pop_front();
          if (pulse !== e.pulse || idx !== e.idx || i != e.rel) begin
            fails++; $display("[TB] FAIL single_strobe got %b/%0d@%0d want %b/%0d@%0d", pulse, idx, i, e.pulse, e.idx, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (i <= 5)) begin fails++; $display("[TB] FAIL single_busy cycle %0d got %b want %b", i, busy, (i <= 5)); end
      if (i == 3) begin
        checks++;
        if (idx !== 2'd2) begin fails++; $display("[TB] FAIL single_index got %0d want 2", idx); end
      end
      if (i == 5) req = 4'hF;
    end
    checks++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL single_missing %0d strobes not seen, want 0", expQ.size()); expQ.delete(); end
  endtask

  // Simultaneous requests on channels 0 and 3: channel 0 wins
  task automatic test_priority();
    strobe_t e;
    rpt = 1'b0;
    req = 4'b0110;
    expQ.push_back('{rel: 1, pulse: 4'b1110, idx: 2'd0});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (pulse !== 4'hF) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++; $display("[TB] FAIL priority_strobe unexpected pulse %b at cycle %0d", pulse, i);
        end else begin
          e = expQ.pop_front();
          if (pulse !== e.pulse || idx !== e.idx || i != e.rel) begin
            fails++; $display("[TB] FAIL priority_strobe got %b/%0d@%0d want %b/%0d@%0d", pulse, idx, i, e.pulse, e.idx, e.rel);
          end
        end
      end
      checks++;
      if (busy !== (i <= 3)) begin fails++; $display("[TB] FAIL priority_busy cycle %0d got %b want %b", i, busy, (i <= 3)); end
      if (i == 2) begin
        checks++;
        if (idx !== 2'd0) begin fails++; $display("[TB] FAIL priority_index got %0d want 0", idx); end
      end
      if (i == 3) req = 4'hF;
    end
    checks++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL priority_missing %0d strobes not seen, want 0", expQ.size()); expQ.delete(); end
  endtask

  // Channel 1 held 60 cycles with auto-repeat: strobes at 0,17,26,35,44,53
  task automatic test_autorepeat();
    strobe_t e;
    int offs[6] = '{0, 17, 26, 35, 44, 53};
    rpt = 1'b1;
    req = 4'b1101;
    foreach (offs[k]) expQ.push_back('{rel: 1 + offs[k], pulse: 4'b1101, idx: 2'd1});
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (pulse !== 4'hF) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++; $display("[TB] FAIL repeat_strobe unexpected pulse %b at cycle %0d", pulse, i);
        end else begin
          e = expQ.pop_front();
          if (pulse !== e.pulse || idx !== e.idx || i != e.rel) begin
            fails++; $display("[TB] FAIL repeat_strobe got %b/%0d@%0d want %b/%0d@%0d", pulse, idx, i, e.pulse, e.idx, e.rel);
          end
        end
      end
      if (i == 60) req = 4'hF;
    end
    checks++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL repeat_missing %0d strobes not seen, want 0", expQ.size()); expQ.delete(); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL repeat_busy_after_release got %b want 0", busy); end
    rpt = 1'b0;
  endtask

  // Release on the very cycle the counter hits the delay limit
  task automatic test_release_at_limit();
    strobe_t e;
    rpt = 1'b1;
    req = 4'b1101;
    expQ.push_back('{rel: 1, pulse: 4'b1101, idx: 2'd1});
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pulse !== 4'hF) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++; $display("[TB] FAIL limit_strobe unexpected pulse %b at cycle %0d", pulse, i);
        end else begin
          e = expQ.pop_front();
          if (pulse !== e.pulse || idx !== e.idx || i != e.rel) begin
            fails++; $display("[TB] FAIL limit_strobe got %b/%0d@%0d want %b/%0d@%0d", pulse, idx, i, e.pulse, e.idx, e.rel);
          end
        end
      end
      if (i == 17) begin
        checks++;
        if (dut.repeatCount !== 5'd15) begin fails++; $display("[TB] FAIL limit_count got %0d want 15", dut.repeatCount); end
        req = 4'hF;
      end
      if (i == 18) begin
        checks++;
        if (dut.state !== CHECK_0 || busy !== 1'b0) begin
          fails++; $display("[TB] FAIL limit_state got state %0d busy %b want %0d/0", dut.state, busy, CHECK_0);
        end
      end
    end
    checks++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL limit_missing %0d strobes not seen, want 0", expQ.size()); expQ.delete(); end
    rpt = 1'b0;
  endtask

  // Reset asserted in HOLD_0 with the request still held
  task automatic test_reset_in_hold();
    strobe_t e;
    rpt = 1'b0;
    req = 4'b1011;
    expQ.push_back('{rel: 1, pulse: 4'b1011, idx: 2'd2});
    expQ.push_back('{rel: 7, pulse: 4'b1011, idx: 2'd2});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pulse !== 4'hF) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++; $display("[TB] FAIL rsthold_strobe unexpected pulse %b at cycle %0d", pulse, i);
        end else begin
          e = expQ.pop_front();
          if (pulse !== e.pulse || idx !== e.idx || i != e.rel) begin
            fails++; $display("[TB] FAIL rsthold_strobe got %b/%0d@%0d want %b/%0d@%0d", pulse, idx, i, e.pulse, e.idx, e.rel);
          end
        end
      end
      checks++;
      if (busy !== ((i <= 3) || (i >= 7 && i <= 9))) begin
        fails++; $display("[TB] FAIL rsthold_busy cycle %0d got %b want %b", i, busy, ((i <= 3) || (i >= 7 && i <= 9)));
      end
      if (i == 3) begin
        rstN = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pulse !== 4'hF || idx !== 2'd0) begin
          fails++; $display("[TB] FAIL rsthold_abort got busy %b pulse %b idx %0d want 0/1111/0", busy, pulse, idx);
        end
      end
      if (i == 4) rstN = 1'b1;
      if (i == 9) req = 4'hF;
    end
    checks++;
    if (expQ.size() != 0) begin fails++; $display("[TB] FAIL rsthold_missing %0d strobes not seen, want 0", expQ.size()); expQ.delete(); end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_single();
    test_priority();
    test_autorepeat();
    test_release_at_limit();
    test_reset_in_hold();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
